// File: rtl/div_issue_pkg.sv
// Shared constants for the divider issue stage: M-extension op codes and the FSM state encoding.
// The DIV_ISSUE_FAST_EN build option is handled in div_issue.sv and div_fast_chk.sv.
package div_issue_pkg;

    localparam logic [2:0] INST_DIV  = 3'b100;
    localparam logic [2:0] INST_DIVU = 3'b101;
    localparam logic [2:0] INST_REM  = 3'b110;
    localparam logic [2:0] INST_REMU = 3'b111;

    // One-hot, so every output decode is a single flop bit.
    typedef enum logic [2:0] {
        ST_IDLE = 3'b001,
        ST_RUN  = 3'b010,
        ST_DONE = 3'b100
    } div_state_t;

    function automatic logic op_is_signed(input logic [2:0] op);
        return (op == INST_DIV) || (op == INST_REM);
    endfunction

    function automatic logic op_is_rem(input logic [2:0] op);
        return (op == INST_REM) || (op == INST_REMU);
    endfunction

endpackage

// File: rtl/div_fast_chk.sv
// Combinational detector for the cases RISC-V defines without dividing: divide by zero
// and signed overflow (MIN / -1). Only instantiated when DIV_ISSUE_FAST_EN is defined.
module div_fast_chk
    import div_issue_pkg::*;
#(
    parameter int DATA_W = 32
) (
    input  logic [2:0]        op,
    input  logic [DATA_W-1:0] rs1,
    input  logic [DATA_W-1:0] rs2,
    output logic              hit,
    output logic [DATA_W-1:0] result
);

    localparam logic [DATA_W-1:0] MIN_VAL = {1'b1, {(DATA_W-1){1'b0}}};

    logic div_zero;
    logic overflow;

    assign div_zero = (rs2 == '0);
    assign overflow = op_is_signed(op) && (rs1 == MIN_VAL) && (rs2 == '1);
    assign hit      = div_zero || overflow;

    always_comb begin
        result = '0;
        if (div_zero) begin
            result = op_is_rem(op) ? rs1 : '1;
        end else if (overflow) begin
            result = op_is_rem(op) ? '0 : MIN_VAL;
        end
    end

endmodule

// File: rtl/div_issue.sv
// Issue/retire stage in front of the iterative divider: latches a request, holds start_o
// for the whole operation, consumes the result and hands it to WB. Option: DIV_ISSUE_FAST_EN.
module div_issue
    import div_issue_pkg::*;
#(
    parameter int DATA_W = 32,
    parameter int REG_AW = 5
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req_valid_i,
    output logic              req_ready_o,
    input  logic [2:0]        req_op_i,
    input  logic [DATA_W-1:0] req_rs1_i,
    input  logic [DATA_W-1:0] req_rs2_i,
    input  logic [REG_AW-1:0] req_rd_i,
    input  logic              flush_i,
    output logic              busy_o,
    output logic              start_o,
    output logic [2:0]        op_o,
    output logic [DATA_W-1:0] dividend_o,
    output logic [DATA_W-1:0] divisor_o,
    input  logic [DATA_W-1:0] result_i,
    input  logic              res_valid_i,
    output logic              res_ready_o,
    output logic              wb_valid_o,
    input  logic              wb_ready_i,
    output logic [DATA_W-1:0] wb_data_o,
    output logic [REG_AW-1:0] wb_rd_o
);

    div_state_t        state_reg;
    logic              kill_reg;
    logic              fast_reg;
    logic [DATA_W-1:0] fast_res_reg;
    logic              req_hsk;
    logic              kill_now;

    assign req_ready_o = (state_reg == ST_IDLE) && !flush_i;
    assign req_hsk     = req_valid_i && req_ready_o;
    assign busy_o      = (state_reg != ST_IDLE);
    assign start_o     = (state_reg == ST_RUN) && !fast_reg;
    assign res_ready_o = start_o && res_valid_i;
    assign wb_valid_o  = (state_reg == ST_DONE);
    // A flush arriving in the same cycle as the result still discards it.
    assign kill_now    = kill_reg || flush_i;

`ifdef DIV_ISSUE_FAST_EN
    logic              fast_hit;
    logic [DATA_W-1:0] fast_res;

    div_fast_chk #(
        .DATA_W (DATA_W)
    ) u_fast_chk (
        .op     (req_op_i),
        .rs1    (req_rs1_i),
        .rs2    (req_rs2_i),
        .hit    (fast_hit),
        .result (fast_res)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            fast_reg     <= 1'b0;
            fast_res_reg <= '0;
        end else if (req_hsk) begin
            fast_reg     <= fast_hit;
            fast_res_reg <= fast_res;
        end
    end
`else
    assign fast_reg     = 1'b0;
    assign fast_res_reg = '0;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg  <= ST_IDLE;
            kill_reg   <= 1'b0;
            op_o       <= '0;
            dividend_o <= '0;
            divisor_o  <= '0;
            wb_data_o  <= '0;
            wb_rd_o    <= '0;
        end else begin
            case (state_reg)
                ST_IDLE: begin
                    if (req_hsk) begin
                        op_o       <= req_op_i;
                        dividend_o <= req_rs1_i;
                        divisor_o  <= req_rs2_i;
                        wb_rd_o    <= req_rd_i;
                        kill_reg   <= 1'b0;
                        state_reg  <= ST_RUN;
                    end
                end
                ST_RUN: begin
                    if (flush_i) begin
                        kill_reg <= 1'b1;
                    end
                    // start_o stays high until the divider hands back its result, so a
                    // killed op still drains cleanly through a non-aborting divider.
                    if (fast_reg) begin
                        wb_data_o <= fast_res_reg;
                        state_reg <= kill_now ? ST_IDLE : ST_DONE;
                    end else if (res_valid_i) begin
                        wb_data_o <= result_i;
                        state_reg <= kill_now ? ST_IDLE : ST_DONE;
                    end
                end
                ST_DONE: begin
                    if (flush_i || wb_ready_i) begin
                        state_reg <= ST_IDLE;
                    end
                end
                default: state_reg <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_div_issue.sv
// Self-checking bench for div_issue: a behavioural divider with random latency sits on the
// divider side; expected WB values come from plain RISC-V division arithmetic.
module tb_div_issue;
    import div_issue_pkg::*;

    logic        clk = 1'b0;
    logic        rst;
    logic        req_valid_i, req_ready_o;
    logic [2:0]  req_op_i;
    logic [31:0] req_rs1_i, req_rs2_i;
    logic [4:0]  req_rd_i;
    logic        flush_i, busy_o, start_o;
    logic [2:0]  op_o;
    logic [31:0] dividend_o, divisor_o, result_i;
    logic        res_valid_i, res_ready_o;
    logic        wb_valid_o, wb_ready_i;
    logic [31:0] wb_data_o;
    logic [4:0]  wb_rd_o;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    div_issue dut (
        .clk         (clk),
        .rst         (rst),
        .req_valid_i (req_valid_i),
        .req_ready_o (req_ready_o),
        .req_op_i    (req_op_i),
        .req_rs1_i   (req_rs1_i),
        .req_rs2_i   (req_rs2_i),
        .req_rd_i    (req_rd_i),
        .flush_i     (flush_i),
        .busy_o      (busy_o),
        .start_o     (start_o),
        .op_o        (op_o),
        .dividend_o  (dividend_o),
        .divisor_o   (divisor_o),
        .result_i    (result_i),
        .res_valid_i (res_valid_i),
        .res_ready_o (res_ready_o),
        .wb_valid_o  (wb_valid_o),
        .wb_ready_i  (wb_ready_i),
        .wb_data_o   (wb_data_o),
        .wb_rd_o     (wb_rd_o)
    );

    // RISC-V M-extension semantics, straight from the ISA rules.
    function automatic logic [31:0] ref_div(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
        int  sa, sb;
        logic ovf;
        sa  = a;
        sb  = b;
        ovf = (a == 32'h8000_0000) && (b == 32'hFFFF_FFFF);
        case (op)
            INST_DIV:  return (b == 0) ? 32'hFFFF_FFFF : (ovf ? a : sa / sb);
            INST_DIVU: return (b == 0) ? 32'hFFFF_FFFF : a / b;
            INST_REM:  return (b == 0) ? a : (ovf ? 32'h0 : sa % sb);
            INST_REMU: return (b == 0) ? a : a % b;
            default:   return 32'h0;
        endcase
    endfunction

    // Behavioural divider: latches operands when start_o rises, answers after lat_lo..lat_hi
    // cycles, holds res_valid_i until res_ready_o, then waits for start_o to drop.
    int   lat_lo = 1, lat_hi = 6;
    logic dv_busy, dv_wait_low;
    int   dv_cnt;
    int   res_pulses = 0;
    int   start_cycles = 0;

    always @(posedge clk) begin
        if (rst) begin
            res_valid_i <= 1'b0;
            result_i    <= '0;
            dv_busy     <= 1'b0;
            dv_wait_low <= 1'b0;
            dv_cnt      <= 0;
        end else if (dv_wait_low) begin
            if (!start_o) dv_wait_low <= 1'b0;
        end else if (!dv_busy) begin
            if (start_o) begin
                dv_busy  <= 1'b1;
                dv_cnt   <= $urandom_range(lat_hi, lat_lo);
                result_i <= ref_div(op_o, dividend_o, divisor_o);
            end
        end else if (!start_o) begin
            dv_busy     <= 1'b0;
            res_valid_i <= 1'b0;
        end else if (res_valid_i) begin
            if (res_ready_o) begin
                res_valid_i <= 1'b0;
                dv_busy     <= 1'b0;
                dv_wait_low <= 1'b1;
            end
        end else if (dv_cnt <= 1) begin
            res_valid_i <= 1'b1;
        end else begin
            dv_cnt <= dv_cnt - 1;
        end
    end

    always @(posedge clk) if (res_valid_i && res_ready_o) res_pulses <= res_pulses + 1;
    always @(negedge clk) if (start_o) start_cycles <= start_cycles + 1;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Called just after a posedge; returns just after the accepting posedge.
    task automatic issue(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b, input logic [4:0] rd);
        logic acc;
        acc = 1'b0;
        req_valid_i = 1'b1;
        req_op_i = op;
        req_rs1_i = a;
        req_rs2_i = b;
        req_rd_i = rd;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (req_ready_o) begin
                acc = 1'b1;
                break;
            end
            @(posedge clk); #1;
        end
        chk("accept", acc, 1'b1);
        @(posedge clk); #1;
        req_valid_i = 1'b0;
    endtask

    // Waits (at negedges) for wb_valid_o; lat counts negedges, low counts RUN cycles with start_o low.
    task automatic wait_wb(output int lat, output int low);
        logic seen;
        seen = 1'b0;
        lat = 0;
        low = 0;
        for (int i = 0; i < 60; i++) begin
            @(negedge clk);
            lat++;
            if (wb_valid_o) begin
                seen = 1'b1;
                break;
            end
            if (!start_o) low++;
        end
        chk("wb_valid_seen", seen, 1'b1);
    endtask

    // At a negedge with wb_valid_o high: check, stall for delay cycles, then complete the handshake.
    task automatic finish_wb(input int delay, input logic [31:0] exp_data, input logic [4:0] exp_rd, input string tag);
        chk({tag, "_data"}, wb_data_o, exp_data);
        chk({tag, "_rd"}, wb_rd_o, exp_rd);
        for (int i = 0; i < delay; i++) begin
            @(posedge clk); #1;
            @(negedge clk);
            chk({tag, "_hold_valid"}, wb_valid_o, 1'b1);
            chk({tag, "_hold_data"}, wb_data_o, exp_data);
        end
        @(posedge clk); #1;
        wb_ready_i = 1'b1;
        @(posedge clk); #1;
        wb_ready_i = 1'b0;
        @(negedge clk);
        chk({tag, "_idle"}, busy_o, 1'b0);
        chk({tag, "_wb_drop"}, wb_valid_o, 1'b0);
    endtask

    task automatic run_op(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b, input logic [4:0] rd, input int delay, input string tag);
        int lat, low;
        logic [31:0] exp;
        exp = ref_div(op, a, b);
        issue(op, a, b, rd);
        wait_wb(lat, low);
        finish_wb(delay, exp, rd, tag);
        @(posedge clk); #1;
        $display("op=%0d a=%h b=%h rd=%0d lat=%0d exp=%h got=%h", op, a, b, rd, lat, exp, wb_data_o);
    endtask

    initial begin
        int lat, low, p0, s0;
        logic seen_wb, still_start;
        logic [2:0] rop;
        logic [31:0] ra, rb;

        rst = 1'b1;
        req_valid_i = 1'b0;
        req_op_i = '0;
        req_rs1_i = '0;
        req_rs2_i = '0;
        req_rd_i = '0;
        flush_i = 1'b0;
        wb_ready_i = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        @(negedge clk);
        chk("rst_busy", busy_o, 1'b0);
        chk("rst_start", start_o, 1'b0);
        chk("rst_wb_valid", wb_valid_o, 1'b0);
        chk("rst_res_ready", res_ready_o, 1'b0);
        chk("rst_req_ready", req_ready_o, 1'b1);
        chk("rst_wb_data", wb_data_o, 32'h0);
        chk("rst_op", {29'h0, op_o}, 32'h0);
        @(posedge clk); #1;
        rst = 1'b0;

        // DIVU 100/7: start_o held through RUN, one result pulse.
        p0 = res_pulses;
        issue(INST_DIVU, 32'd100, 32'd7, 5'd3);
        @(negedge clk);
        chk("divu_start", start_o, 1'b1);
        chk("divu_dividend", dividend_o, 32'd100);
        wait_wb(lat, low);
        chk("divu_start_gap", low, 0);
        chk("divu_start_drop", start_o, 1'b0);
        chk("divu_res_pulses", res_pulses - p0, 1);
        finish_wb(0, 32'd14, 5'd3, "divu");
        $display("DIVU 100/7 -> %h rd=%0d", wb_data_o, wb_rd_o);
        @(posedge clk); #1;

        // REM -7/2 with a 5-cycle WB stall.
        run_op(INST_REM, 32'hFFFF_FFF9, 32'd2, 5'd5, 5, "rem_stall");

        // Flush three cycles after accept: result drained from the divider but never written back.
        lat_lo = 8;
        lat_hi = 8;
        p0 = res_pulses;
        issue(INST_DIV, 32'd50, 32'd5, 5'd7);
        repeat (3) begin
            @(posedge clk); #1;
        end
        flush_i = 1'b1;
        @(posedge clk); #1;
        flush_i = 1'b0;
        @(negedge clk);
        still_start = start_o;
        chk("flush_start_held", still_start, 1'b1);
        seen_wb = 1'b0;
        for (int i = 0; i < 30 && busy_o; i++) begin
            @(negedge clk);
            if (wb_valid_o) seen_wb = 1'b1;
        end
        chk("flush_no_wb", seen_wb, 1'b0);
        chk("flush_idle", busy_o, 1'b0);
        chk("flush_drained", res_pulses - p0, 1);
        $display("DIV 50/5 flushed: wb_seen=%0d", seen_wb);
        @(posedge clk); #1;
        lat_lo = 1;
        lat_hi = 6;

        // Flush wins over wb_ready_i in DONE.
        issue(INST_DIVU, 32'd20, 32'd4, 5'd9);
        wait_wb(lat, low);
        @(posedge clk); #1;
        flush_i = 1'b1;
        wb_ready_i = 1'b1;
        @(posedge clk); #1;
        flush_i = 1'b0;
        wb_ready_i = 1'b0;
        @(negedge clk);
        chk("done_flush_wb", wb_valid_o, 1'b0);
        chk("done_flush_idle", busy_o, 1'b0);
        $display("DIVU 20/4 flushed in DONE");
        @(posedge clk); #1;

        // Flush in IDLE blocks acceptance.
        req_valid_i = 1'b1;
        req_op_i = INST_DIV;
        flush_i = 1'b1;
        @(negedge clk);
        chk("idle_flush_ready", req_ready_o, 1'b0);
        @(posedge clk); #1;
        req_valid_i = 1'b0;
        flush_i = 1'b0;
        @(negedge clk);
        chk("idle_flush_busy", busy_o, 1'b0);
        $display("flush in IDLE: no accept");
        @(posedge clk); #1;

        // DIV 1/0.
        s0 = start_cycles;
        issue(INST_DIV, 32'd1, 32'd0, 5'd11);
        wait_wb(lat, low);
`ifdef DIV_ISSUE_FAST_EN
        chk("div0_fast_lat", lat, 2);
        chk("div0_fast_nostart", start_cycles - s0, 0);
`endif
        finish_wb(0, 32'hFFFF_FFFF, 5'd11, "div0");
        $display("DIV 1/0 -> %h lat=%0d", wb_data_o, lat);
        @(posedge clk); #1;

        // Signed overflow.
        run_op(INST_DIV, 32'h8000_0000, 32'hFFFF_FFFF, 5'd12, 1, "div_ovf");
        run_op(INST_REM, 32'h8000_0000, 32'hFFFF_FFFF, 5'd13, 0, "rem_ovf");

        // Reset pulse mid-RUN, then a fresh op.
        lat_lo = 10;
        lat_hi = 10;
        issue(INST_DIVU, 32'd1000, 32'd3, 5'd14);
        @(posedge clk); #1;
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        chk("rst_mid_busy", busy_o, 1'b0);
        chk("rst_mid_start", start_o, 1'b0);
        $display("reset mid-RUN: busy=%0d start=%0d", busy_o, start_o);
        @(posedge clk); #1;
        lat_lo = 1;
        lat_hi = 6;
        run_op(INST_DIVU, 32'd9, 32'd3, 5'd15, 0, "post_rst");

        // Random traffic, including the divide-by-zero and overflow corners.
        for (int n = 0; n < 24; n++) begin
            rop = INST_DIV | 3'($urandom_range(3, 0));
            ra = $urandom;
            rb = $urandom;
            case ($urandom_range(7, 0))
                0: rb = 32'h0;
                1: begin ra = 32'h8000_0000; rb = 32'hFFFF_FFFF; end
                2: begin ra = $urandom_range(1000, 0); rb = $urandom_range(20, 1); end
                3: rb = $urandom_range(255, 1);
                default: ;
            endcase
            run_op(rop, ra, rb, 5'($urandom_range(31, 0)), $urandom_range(3, 0), "rand");
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
